// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM handshake, data word, and arbiter state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISVC  = 2'd1,
        DSVC  = 2'd2,
        DLOCK = 2'd3
    } arb_state_t;

    // Word-address bit that selects word 0 / word 1 of a two-word dcache block.
    localparam int BLK_OFF_BIT = 2;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter with synchronous clear and a threshold flag.
module arb_starve_ctr #(
    parameter int MAX = 8,
    parameter int W   = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic starved
);

    logic [W-1:0] count;

    // NOTE: non-blocking assignments for registered state so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign starved = (int'(count) >= MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single RAM port shared between icache fetches and dcache block traffic.
// dcache has priority and its two-word blocks are never split; starvation bounds icache latency.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ISTARVE_MAX = 8
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      ramerr
);

    arb_state_t state, next_state;
    logic       d_req;
    logic       ram_done;
    logic       i_done;
    logic       i_starved;

    assign d_req    = dREN | dWEN;
    assign ram_done = (ramstate == ACCESS);
    assign i_done   = (state == ISVC) && iREN && ram_done;

    assign iload = ramload;
    assign dload = ramload;

    arb_starve_ctr #(
        .MAX (ISTARVE_MAX),
        .W   (4)
    ) u_starve (
        .CLK     (CLK),
        .RST     (RST),
        .inc     (iREN && (state != ISVC)),
        .clr     (i_done || !iREN),
        .starved (i_starved)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (iREN && i_starved) begin
                    next_state = ISVC;
                end else if (d_req) begin
                    next_state = DSVC;
                end else if (iREN) begin
                    next_state = ISVC;
                end
            end
            ISVC: begin
                if (!iREN || ram_done) begin
                    next_state = IDLE;
                end
            end
            DSVC: begin
                if (!d_req) begin
                    next_state = IDLE;
                end else if (ram_done) begin
                    next_state = daddr[BLK_OFF_BIT] ? IDLE : DLOCK;
                end
            end
            DLOCK: begin
                // Word 0 completing here starts another block without re-arbitrating.
                if (!d_req) begin
                    next_state = IDLE;
                end else if (ram_done && daddr[BLK_OFF_BIT]) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        unique case (state)
            ISVC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iwait   = ~i_done;
            end
            DSVC, DLOCK: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~(d_req && ram_done);
            end
            default: ;
        endcase
    end

    // Sticky error flag: any ERROR response while a grant is held.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ramerr <= 1'b0;
        end else if ((state != IDLE) && (ramstate == ERROR)) begin
            ramerr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: requester queues, a reactive RAM model,
// and an expected-completion queue checked whenever iwait or dwait drops.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      iwait, dwait, ramREN, ramWEN, ramerr;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    typedef struct {
        logic  is_i;
        logic  wr;
        word_t addr;
        word_t data;
    } exp_t;

    typedef struct {
        logic  wr;
        word_t addr;
        word_t data;
    } dreq_t;

    exp_t  exp_q[$];
    dreq_t d_q[$];
    word_t i_q[$];

    int checks = 0;
    int errors = 0;
    int busy_left = 0;
    int err_left  = 0;
    int ren_cycles, wen_cycles, iw0, dw0;

    always #5 CLK = ~CLK;

    function automatic word_t rd_data(word_t a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic word_t wr_data(word_t a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // RAM model: read data follows the address; responses scripted by err_left/busy_left.
    assign ramload  = rd_data(ramaddr);
    assign ramstate = !(ramREN || ramWEN) ? FREE :
                      (err_left > 0)      ? ERROR :
                      (busy_left > 0)     ? BUSY  : ACCESS;

    mem_arbiter #(.ISTARVE_MAX(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ramerr   (ramerr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic score(input logic is_i);
        exp_t e;
        check(is_i ? "sb_has_i" : "sb_has_d", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("sb_port", 32'(is_i), 32'(e.is_i));
        check("sb_addr", ramaddr, e.addr);
        check("sb_wen", 32'(ramWEN), 32'(e.wr));
        check("sb_ren", 32'(ramREN), 32'(!e.wr));
        check("sb_data", e.wr ? ramstore : (is_i ? iload : dload), e.data);
    endtask

    task automatic drive();
        iREN  = (i_q.size() > 0);
        iaddr = (i_q.size() > 0) ? i_q[0] : '0;
        if (d_q.size() > 0) begin
            dWEN   = d_q[0].wr;
            dREN   = !d_q[0].wr;
            daddr  = d_q[0].addr;
            dstore = d_q[0].data;
        end else begin
            dWEN   = 1'b0;
            dREN   = 1'b0;
            daddr  = '0;
            dstore = '0;
        end
    endtask

    // Sample at negedge; advance requesters and the RAM script just after the next posedge.
    task automatic tick();
        logic i_fin, d_fin, strobe;
        @(negedge CLK);
        i_fin  = !iwait;
        d_fin  = !dwait;
        strobe = ramREN || ramWEN;
        ren_cycles += int'(ramREN);
        wen_cycles += int'(ramWEN);
        if (i_fin) begin iw0++; score(1'b1); end
        if (d_fin) begin dw0++; score(1'b0); end
        @(posedge CLK);
        #1;
        if (i_fin && i_q.size() > 0) void'(i_q.pop_front());
        if (d_fin && d_q.size() > 0) void'(d_q.pop_front());
        if (strobe) begin
            if (err_left > 0) err_left--;
            else if (busy_left > 0) busy_left--;
        end
        drive();
    endtask

    task automatic run_until_done(input string tag, input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || d_q.size() != 0 || i_q.size() != 0) && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size() + d_q.size() + i_q.size()), 32'd0);
    endtask

    task automatic clear_stats();
        ren_cycles = 0;
        wen_cycles = 0;
        iw0 = 0;
        dw0 = 0;
    endtask

    task automatic push_d(input logic wr, input word_t a);
        dreq_t r;
        exp_t  e;
        r.wr = wr; r.addr = a; r.data = wr_data(a);
        d_q.push_back(r);
        e.is_i = 1'b0; e.wr = wr; e.addr = a; e.data = wr ? wr_data(a) : rd_data(a);
        exp_q.push_back(e);
    endtask

    task automatic push_i_req(input word_t a);
        i_q.push_back(a);
    endtask

    task automatic push_i_exp(input word_t a);
        exp_t e;
        e.is_i = 1'b1; e.wr = 1'b0; e.addr = a; e.data = rd_data(a);
        exp_q.push_back(e);
    endtask

    initial begin
        RST = 1'b1;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        clear_stats();
        #1;
        check("rst_ramREN", 32'(ramREN), 32'd0);
        check("rst_ramWEN", 32'(ramWEN), 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_iwait", 32'(iwait), 32'd1);
        check("rst_dwait", 32'(dwait), 32'd1);
        check("rst_ramerr", 32'(ramerr), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset in the middle of a held dcache write.
        d_q.push_back('{wr: 1'b1, addr: 32'h200, data: 32'h1234});
        busy_left = 100;
        drive();
        tick();
        tick();
        check("t1_wen_before_rst", 32'(ramWEN), 32'd1);
        RST = 1'b1;
        #1;
        check("t1_wen_in_rst", 32'(ramWEN), 32'd0);
        check("t1_dwait_in_rst", 32'(dwait), 32'd1);
        d_q.delete();
        busy_left = 0;
        drive();
        tick();
        RST = 1'b0;
        tick();
        check("t1_state_idle", 32'(dut.state), 32'(IDLE));
        check("t1_ramerr", 32'(ramerr), 32'd0);
        check("t1_no_strobe", 32'(ramREN | ramWEN), 32'd0);

        // Icache alone, two BUSY cycles before ACCESS.
        clear_stats();
        push_i_req(32'h40);
        push_i_exp(32'h40);
        busy_left = 2;
        drive();
        run_until_done("t2_done", 20);
        check("t2_ren_cycles", 32'(ren_cycles), 32'd3);
        check("t2_iwait_low", 32'(iw0), 32'd1);

        // Simultaneous requests: dcache block first, unsplit, icache after.
        clear_stats();
        push_d(1'b0, 32'h100);
        push_d(1'b0, 32'h104);
        push_i_req(32'h300);
        push_i_exp(32'h300);
        drive();
        run_until_done("t3_done", 30);
        check("t3_dwait_low", 32'(dw0), 32'd2);

        // Sustained writeback: icache wins at the first block boundary after starving 8 cycles.
        clear_stats();
        for (int k = 0; k < 6; k++) push_d(1'b1, 32'h1000 + 32'(4 * k));
        push_i_req(32'h600);
        push_i_exp(32'h600);
        for (int k = 6; k < 8; k++) push_d(1'b1, 32'h1000 + 32'(4 * k));
        drive();
        run_until_done("t4_done", 60);
        check("t4_wen_cycles", 32'(wen_cycles), 32'd8);

        // Single-word flush write, then icache.
        clear_stats();
        push_d(1'b1, 32'h3100);
        push_i_req(32'h500);
        push_i_exp(32'h500);
        drive();
        run_until_done("t5_done", 30);
        check("t5_one_write", 32'(wen_cycles), 32'd1);
        check("t5_ramerr_clear", 32'(ramerr), 32'd0);

        // ERROR during an icache grant: sticky flag, transfer still completes.
        clear_stats();
        push_i_req(32'h80);
        push_i_exp(32'h80);
        err_left = 1;
        drive();
        run_until_done("t6_done", 20);
        check("t6_iwait_low", 32'(iw0), 32'd1);
        check("t6_ramerr_set", 32'(ramerr), 32'd1);
        repeat (3) tick();
        check("t6_ramerr_sticky", 32'(ramerr), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
